// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel position, h/v sync, active-draw, new-frame strobe, frame count.
// Latency: the N-th rising edge after reset release presents raster position N-1; all outputs are registered.
// Backpressure: none; free-running at one pixel per clock, and downstream must keep up.
//
// Ports:
//   pixel_clk_in  pixel clock
//   rst_n_in      asynchronous active-low reset; clears every output immediately
//   hcount_out    horizontal position 0..TOTAL_H-1
//   vcount_out    vertical position 0..TOTAL_V-1
//   hs_out        horizontal sync, active high
//   vs_out        vertical sync, active high, held for whole lines
//   ad_out        high inside the visible area
//   nf_out        one-cycle strobe at (ACTIVE_H, ACTIVE_V), the start of vertical blanking
//   fc_out        frame count modulo 2^FC_WIDTH, steps together with nf_out
module video_timing_gen #(
    parameter int ACTIVE_H = 1280,
    parameter int FP_H     = 110,
    parameter int SYNC_H   = 40,
    parameter int BP_H     = 220,
    parameter int ACTIVE_V = 720,
    parameter int FP_V     = 5,
    parameter int SYNC_V   = 5,
    parameter int BP_V     = 20,
    parameter int FC_WIDTH = 6
) (
    input  logic                pixel_clk_in,
    input  logic                rst_n_in,
    output logic [10:0]         hcount_out,
    output logic [9:0]          vcount_out,
    output logic                hs_out,
    output logic                vs_out,
    output logic                ad_out,
    output logic                nf_out,
    output logic [FC_WIDTH-1:0] fc_out
);

    localparam int TOTAL_H  = ACTIVE_H + FP_H + SYNC_H + BP_H;
    localparam int TOTAL_V  = ACTIVE_V + FP_V + SYNC_V + BP_V;
    localparam int HS_START = ACTIVE_H + FP_H;
    localparam int HS_END   = ACTIVE_H + FP_H + SYNC_H;
    localparam int VS_START = ACTIVE_V + FP_V;
    localparam int VS_END   = ACTIVE_V + FP_V + SYNC_V;

    localparam logic [10:0] H_LAST = 11'(TOTAL_H - 1);
    localparam logic [9:0]  V_LAST = 10'(TOTAL_V - 1);

    generate
        if (TOTAL_H > 2048 || TOTAL_V > 1024) begin : g_bad_totals
            $error("video_timing_gen: TOTAL_H must be <= 2048 and TOTAL_V <= 1024");
        end
    endgenerate

    // Reset parks the outputs at (0,0) with ad low. The first edge after
    // release must present (0,0) again, this time with its real flags, so
    // position only starts advancing once this flag is set.
    logic        started;
    logic [10:0] next_h;
    logic [9:0]  next_v;
    logic        next_hs;
    logic        next_vs;
    logic        next_ad;
    logic        next_nf;

    always_comb begin
        next_h = '0;
        next_v = '0;
        if (started) begin
            if (hcount_out == H_LAST) begin
                next_h = '0;
                next_v = (vcount_out == V_LAST) ? 10'd0 : vcount_out + 10'd1;
            end else begin
                next_h = hcount_out + 11'd1;
                next_v = vcount_out;
            end
        end
    end

    // Flags are derived from the position about to be registered, so they
    // land in the same cycle as that position with no skew.
    always_comb begin
        next_hs = (int'(next_h) >= HS_START) && (int'(next_h) < HS_END);
        next_vs = (int'(next_v) >= VS_START) && (int'(next_v) < VS_END);
        next_ad = (int'(next_h) < ACTIVE_H) && (int'(next_v) < ACTIVE_V);
        next_nf = (int'(next_h) == ACTIVE_H) && (int'(next_v) == ACTIVE_V);
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            started    <= 1'b0;
            hcount_out <= '0;
            vcount_out <= '0;
            hs_out     <= 1'b0;
            vs_out     <= 1'b0;
            ad_out     <= 1'b0;
            nf_out     <= 1'b0;
            fc_out     <= '0;
        end else begin
            started    <= 1'b1;
            hcount_out <= next_h;
            vcount_out <= next_v;
            hs_out     <= next_hs;
            vs_out     <= next_vs;
            ad_out     <= next_ad;
            nf_out     <= next_nf;
            // Frame count moves with the nf strobe only, never with the (0,0) wrap.
            if (next_nf) begin
                fc_out <= fc_out + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using a shrunken raster so whole frames fit in a short run.
// Horizontal: active 8, fp 2, sync 3, bp 2 -> total 15, hs on h=10..12.
// Vertical:   active 4, fp 1, sync 2, bp 1 -> total 8,  vs on v=5..6; nf at (8,4); frame = 120 cycles.
module tb_video_timing_gen;

    logic        clk;
    logic        rst_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hs;
    logic        vs;
    logic        ad;
    logic        nf;
    logic [5:0]  fc;

    video_timing_gen #(
        .ACTIVE_H(8), .FP_H(2), .SYNC_H(3), .BP_H(2),
        .ACTIVE_V(4), .FP_V(1), .SYNC_V(2), .BP_V(1),
        .FC_WIDTH(6)
    ) dut (
        .pixel_clk_in(clk),
        .rst_n_in    (rst_n),
        .hcount_out  (hcount),
        .vcount_out  (vcount),
        .hs_out      (hs),
        .vs_out      (vs),
        .ad_out      (ad),
        .nf_out      (nf),
        .fc_out      (fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Bench-side reference position and frame count.
    int eh;
    int ev;
    int efc;

    logic [34:0] obs;
    assign obs = {hcount, vcount, hs, vs, ad, nf, fc};

    function automatic logic [34:0] expv(int h, int v, int f);
        logic e_hs;
        logic e_vs;
        logic e_ad;
        logic e_nf;
        e_hs = (h >= 10) && (h < 13);
        e_vs = (v >= 5) && (v < 7);
        e_ad = (h < 8) && (v < 4);
        e_nf = (h == 8) && (v == 4);
        return {11'(h), 10'(v), e_hs, e_vs, e_ad, e_nf, 6'(f)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, want);
        end
    endtask

    // Advance one clock, step the reference, and compare the whole tuple.
    task automatic step_chk(input string tag);
        @(negedge clk);
        eh++;
        if (eh == 15) begin
            eh = 0;
            ev++;
            if (ev == 8) ev = 0;
        end
        if (eh == 8 && ev == 4) efc = (efc + 1) % 64;
        chk(tag, 64'(obs), 64'(expv(eh, ev, efc)));
    endtask

    int hs_cnt;
    int hs_first;
    int nf_cnt;
    int vs_cnt;
    int max_h;
    int max_v;
    int fc_at1;
    int fc_at2;
    int steps;

    initial begin
        rst_n = 1'b0;
        eh = 0; ev = 0; efc = 0;

        // Reset state
        #1;
        chk("reset_state", 64'(obs), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Edge 1 presents (0,0) with ad high
        @(negedge clk);
        chk("edge1", 64'(obs), 64'({11'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0}));

        // Last visible pixel, then first blanking pixel
        repeat (7) step_chk("line0");
        chk("edge8_h", 64'(hcount), 64'd7);
        chk("edge8_ad", 64'(ad), 64'd1);
        step_chk("line0");
        chk("edge9_h", 64'(hcount), 64'd8);
        chk("edge9_ad", 64'(ad), 64'd0);

        // One full line period: hs width/position and the 14 -> 0 wrap
        hs_cnt = 0;
        hs_first = -1;
        for (int i = 0; i < 15; i++) begin
            step_chk("line_scan");
            if (hs) begin
                if (hs_first < 0) hs_first = int'(hcount);
                hs_cnt++;
            end
        end
        chk("hs_width", 64'(hs_cnt), 64'd3);
        chk("hs_first", 64'(hs_first), 64'd10);
        chk("line_period_pos", 64'({hcount, vcount}), 64'({11'd8, 10'd1}));

        // 64 frames: full tuple every cycle, nf/fc sequence, vs coverage, range
        nf_cnt = 0; vs_cnt = 0; max_h = 0; max_v = 0; fc_at1 = -1; fc_at2 = -1;
        for (int i = 0; i < 64 * 120; i++) begin
            step_chk("frames");
            if (nf) begin
                nf_cnt++;
                if (nf_cnt == 1) fc_at1 = int'(fc);
                if (nf_cnt == 2) fc_at2 = int'(fc);
            end
            if (vs) vs_cnt++;
            if (int'(hcount) > max_h) max_h = int'(hcount);
            if (int'(vcount) > max_v) max_v = int'(vcount);
        end
        chk("nf_count", 64'(nf_cnt), 64'd64);
        chk("fc_first_pulse", 64'(fc_at1), 64'd1);
        chk("fc_second_pulse", 64'(fc_at2), 64'd2);
        chk("fc_wrap64", 64'(fc), 64'd0);
        chk("vs_cycles", 64'(vs_cnt), 64'd1920);
        chk("max_h", 64'(max_h), 64'd14);
        chk("max_v", 64'(max_v), 64'd7);

        // Walk to (6,2) with fc=5, then reset asynchronously between edges
        steps = 0;
        while (!(efc == 5 && eh == 6 && ev == 2) && steps < 1000) begin
            step_chk("to_midframe");
            steps++;
        end
        chk("midframe_reached", 64'({fc, hcount, vcount}), 64'({6'd5, 11'd6, 10'd2}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_clear", 64'(obs), 64'd0);
        @(negedge clk);
        chk("reset_held", 64'(obs), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_edge1", 64'(obs), 64'({11'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0}));
        eh = 0; ev = 0; efc = 0;
        repeat (30) step_chk("after_reset");

        // Reset pulse much shorter than a clock period, no edge inside it
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        chk("short_pulse_clear", 64'(obs), 64'd0);
        @(negedge clk);
        chk("short_pulse_edge1", 64'(obs), 64'({11'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0}));
        eh = 0; ev = 0; efc = 0;
        repeat (130) step_chk("after_short_pulse");
        chk("after_short_fc", 64'(fc), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
